// File: rtl/nibble_assembler.sv
// nibble_assembler: LSB-first serial bit assembler with word FIFO, draining one-cycle
// latch strobes with a held output word and a programmable idle gap after each strobe.
module nibble_assembler #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_bit_valid,
   input  logic                         i_bit,
   output logic                         o_bit_ready,
   input  logic                         i_flush,
   output logic                         o_en,
   output logic [WIDTH-1:0]             o_a,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty,
   output logic                         o_full
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

   state_t           r_state;
   logic [BW-1:0]    r_bc;
   logic [WIDTH-2:0] r_shift;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [CW-1:0]    r_count;
   logic [GW-1:0]    r_gc;
   logic             r_en;
   logic [WIDTH-1:0] r_a;
   logic             w_last, w_acc, w_push, w_pop;

   assign w_last      = r_bc == BW'(WIDTH-1);
   assign o_full      = r_count == CW'(DEPTH);
   assign o_empty     = r_count == '0;
   assign o_count     = r_count;
   assign o_en        = r_en;
   assign o_a         = r_a;
   // only the completing bit can stall; a flush cycle always swallows the bit
   assign o_bit_ready = !i_rst && (i_flush || !(w_last && o_full));
   assign w_acc       = i_bit_valid && o_bit_ready && !i_flush;
   assign w_push      = w_acc && w_last;
   assign w_pop       = r_state == S_IDLE && !o_empty && !i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_bc    <= '0;
         r_shift <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_gc    <= '0;
         r_en    <= 1'b0;
         r_a     <= '0;
      end else begin
         if (i_flush) r_bc <= '0;
         else if (w_acc) r_bc <= w_last ? '0 : r_bc + BW'(1);
         if (w_acc && !w_last) r_shift[r_bc] <= i_bit;
         if (w_push) r_mem[r_wp] <= {i_bit, r_shift};
         r_wp    <= i_flush ? '0 : r_wp + AW'(w_push);
         r_rp    <= i_flush ? '0 : r_rp + AW'(w_pop);
         r_count <= i_flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
         case (r_state)
            S_IDLE: if (w_pop) begin
               r_a     <= r_mem[r_rp];
               r_en    <= 1'b1;
               r_state <= S_STROBE;
            end
            S_STROBE: begin
               r_en    <= 1'b0;
               r_gc    <= '0;
               r_state <= GAP == 0 ? S_IDLE : S_GAP;
            end
            default: begin
               r_gc    <= r_gc + GW'(1);
               r_state <= (i_flush || r_gc == GW'(GAP-1)) ? S_IDLE : S_GAP;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(w_push && o_full));
         assert (!(w_pop && o_empty));
      end
   end
endmodule
